frame_loader: RTL and testbench

FRAME_LOADER -- requirements
Module: frame_loader

---
 rtl/dp_pkg.sv | 12 +
 rtl/frame_loader.sv | 73 +++++++
 tb/tb_frame_loader.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/dp_pkg.sv
// Shared datapath definitions: default sample/frame geometry and the loader state encoding.
package dp_pkg;

    localparam int SAMPLE_W_DEF  = 8;
    localparam int FRAME_LEN_DEF = 16;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } loader_state_t;

endpackage

// File: rtl/frame_loader.sv
// Serial-to-parallel frame loader: collects FRAME_LEN signed samples into a frame
// buffer and presents it with a valid/ready handoff to the downstream adder stage.
module frame_loader
    import dp_pkg::*;
#(
    parameter int SAMPLE_W  = SAMPLE_W_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SAMPLE_W-1:0]           in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          flush,
    output logic [FRAME_LEN*SAMPLE_W-1:0] frame_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [15:0]                   frame_count
);

    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    loader_state_t                          state_q, state_d;
    logic [IDX_W-1:0]                       idx_q, idx_d;
    logic [FRAME_LEN-1:0][SAMPLE_W-1:0]     lanes_q, lanes_d;
    logic [15:0]                            count_q, count_d;

    // Flush outranks both accept and handoff; lanes are only written on accept.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lanes_d = lanes_q;
        count_d = count_q;
        if (flush) begin
            state_d = FILL;
            idx_d   = '0;
        end else if (state_q == FILL) begin
            if (in_valid) begin
                lanes_d[idx_q] = in_data;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = FULL;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
        end else if (out_ready) begin
            state_d = FILL;
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FILL;
            idx_q   <= '0;
            lanes_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lanes_q <= lanes_d;
            count_q <= count_d;
        end
    end

    assign in_ready    = (state_q == FILL);
    assign out_valid   = (state_q == FULL);
    assign frame_data  = lanes_q;
    assign frame_count = count_q;

endmodule

// File: tb/tb_frame_loader.sv
// Self-checking bench for frame_loader: a scoreboard queue holds every frame
// the stimulus completes and is drained as the loader presents frames.
module tb_frame_loader;

    localparam int SW = 8;
    localparam int FL = 16;
    localparam int FW = SW * FL;

    logic          clk;
    logic          rst;
    logic [SW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          flush;
    logic [FW-1:0] frame_data;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   frame_count;

    frame_loader #(.SAMPLE_W(SW), .FRAME_LEN(FL)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .flush       (flush),
        .frame_data  (frame_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .frame_count (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int                  assertCount = 0;
    int                  failCount   = 0;
    logic [FL-1:0][SW-1:0] modelLanes;
    int                  modelIdx;
    logic [15:0]         expCount;
    logic [FW-1:0]       sbQueue[$];

    task automatic checkOutput(input string tag, input logic [FW-1:0] observed,
                               input logic [FW-1:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // Drive one sample and hold it until the loader accepts it.
    task automatic applyStimulus(input logic [SW-1:0] d);
        int budget = 50;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && budget > 0) begin
            stepClock();
            budget--;
        end
        if (budget == 0) checkOutput("accept_timeout", 0, 1);
        stepClock();
        in_valid = 1'b0;
        modelLanes[modelIdx] = d;
        if (modelIdx == FL - 1) begin
            sbQueue.push_back(modelLanes);
            modelIdx = 0;
        end else begin
            modelIdx++;
        end
    endtask

    // Wait for a presented frame, hold it for holdCycles, then hand it off.
    task automatic drainFrame(input int holdCycles, input logic pokeInput);
        int budget = 50;
        logic [FW-1:0] exp;
        while (!out_valid && budget > 0) begin
            stepClock();
            budget--;
        end
        checkOutput("out_valid_seen", FW'(out_valid), 1);
        if (sbQueue.size() == 0) begin
            checkOutput("sb_nonempty", 0, 1);
            exp = '0;
        end else begin
            exp = sbQueue.pop_front();
        end
        checkOutput("frame_data", frame_data, exp);
        out_ready = 1'b0;
        if (pokeInput) begin
            in_valid = 1'b1;
            in_data  = 8'h55;
        end
        for (int i = 0; i < holdCycles; i++) begin
            stepClock();
            checkOutput("hold_out_valid", FW'(out_valid), 1);
            checkOutput("hold_in_ready", FW'(in_ready), 0);
            checkOutput("hold_frame_data", frame_data, exp);
        end
        out_ready = 1'b1;
        stepClock();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        expCount  = expCount + 16'd1;
        checkOutput("post_out_valid", FW'(out_valid), 0);
        checkOutput("post_in_ready", FW'(in_ready), 1);
        checkOutput("frame_count", FW'(frame_count), FW'(expCount));
        checkOutput("no_accept_on_handoff", frame_data, exp);
    endtask

    task automatic resetModel();
        modelLanes = '0;
        modelIdx   = 0;
        expCount   = 16'd0;
        sbQueue.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [FW-1:0] discarded;
        rst       = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        resetModel();
        stepClock();
        stepClock();
        checkOutput("rst_in_ready", FW'(in_ready), 1);
        checkOutput("rst_out_valid", FW'(out_valid), 0);
        checkOutput("rst_frame_data", frame_data, 0);
        checkOutput("rst_frame_count", FW'(frame_count), 0);
        rst = 1'b1;

        $display("[TB] basic frame 1..16");
        out_ready = 1'b1;
        for (int i = 1; i <= FL; i++) applyStimulus(SW'(i));
        checkOutput("t1_out_valid", FW'(out_valid), 1);
        checkOutput("t1_lane0", FW'(frame_data[7:0]), 'h01);
        checkOutput("t1_lane15", FW'(frame_data[FW-1 -: SW]), 'h10);
        drainFrame(0, 1'b0);

        $display("[TB] negative samples with backpressure");
        for (int i = 0; i < FL; i++) applyStimulus(8'h80);
        drainFrame(5, 1'b1);

        $display("[TB] flush mid-frame");
        for (int i = 0; i < 7; i++) applyStimulus(SW'(8'h21 + i));
        in_valid = 1'b1;
        in_data  = 8'hEE;
        flush    = 1'b1;
        stepClock();
        flush    = 1'b0;
        in_valid = 1'b0;
        modelIdx = 0;
        checkOutput("flush_no_write", frame_data, modelLanes);
        checkOutput("flush_in_ready", FW'(in_ready), 1);
        for (int i = 0; i < FL; i++) applyStimulus(SW'(8'h30 + i));
        checkOutput("flush_lane0", FW'(frame_data[7:0]), 'h30);
        drainFrame(1, 1'b0);

        $display("[TB] flush against handoff");
        for (int i = 0; i < FL; i++) applyStimulus(SW'(8'h40 + i));
        checkOutput("t4_out_valid", FW'(out_valid), 1);
        discarded = sbQueue.pop_front();
        flush     = 1'b1;
        out_ready = 1'b1;
        stepClock();
        flush     = 1'b0;
        out_ready = 1'b0;
        checkOutput("t4_out_valid_after", FW'(out_valid), 0);
        checkOutput("t4_in_ready_after", FW'(in_ready), 1);
        checkOutput("t4_count_unchanged", FW'(frame_count), FW'(expCount));
        checkOutput("t4_lanes_kept", frame_data, discarded);

        $display("[TB] random frames with gaps");
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < FL; i++) begin
                if ($urandom_range(0, 3) == 0) stepClock();
                applyStimulus(SW'($urandom));
            end
            drainFrame(int'($urandom_range(0, 3)), 1'b0);
        end

        $display("[TB] asynchronous reset mid-frame");
        for (int i = 0; i < 9; i++) applyStimulus(SW'(8'h90 + i));
        #3 rst = 1'b0;
        #1;
        checkOutput("arst_in_ready", FW'(in_ready), 1);
        checkOutput("arst_out_valid", FW'(out_valid), 0);
        checkOutput("arst_frame_data", frame_data, 0);
        checkOutput("arst_frame_count", FW'(frame_count), 0);
        resetModel();
        stepClock();
        rst = 1'b1;
        for (int i = 0; i < FL; i++) applyStimulus(SW'(8'hA0 + i));
        drainFrame(0, 1'b0);

        $display("[TB] frame counter wrap");
        @(negedge clk);
        force dut.count_q = 16'hFFFF;
        @(negedge clk);
        release dut.count_q;
        #1;
        expCount = 16'hFFFF;
        checkOutput("forced_count", FW'(frame_count), 'hFFFF);
        for (int i = 0; i < FL; i++) applyStimulus(SW'(8'hC0 + i));
        drainFrame(0, 1'b0);
        checkOutput("wrap_count_zero", FW'(frame_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
